// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg
//   Shared types for the SPARC memory responder: transfer-size encodings,
//   responder FSM states and the request legality check.
package sparc_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10,
        ERR    = 2'b11
    } state_e;

    // A request is legal when its size is defined and its address is
    // naturally aligned to that size.
    function automatic logic req_legal(input logic [1:0] t, input logic [1:0] a_lo);
        logic ok;
        case (t)
            MEM_BYTE: ok = 1'b1;
            MEM_HALF: ok = ~a_lo[0];
            MEM_WORD: ok = (a_lo == 2'b00);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sparc_ram_responder_if.sv
// sparc_ram_responder_if
//   Request/response bus between the control unit (master) and the memory
//   responder (slave).
//   MOV/R_W/TYPE/SIGN/ADDR/DATA_IN : request from the initiator
//   DATA_OUT/MFC/MAE               : load data, completion and error flags
interface sparc_ram_responder_if #(
    parameter int ADDR_W = 9
);
    logic              MOV;
    logic              R_W;
    logic [1:0]        TYPE;
    logic              SIGN;
    logic [ADDR_W-1:0] ADDR;
    logic [31:0]       DATA_IN;
    logic [31:0]       DATA_OUT;
    logic              MFC;
    logic              MAE;

    modport master (
        output MOV, R_W, TYPE, SIGN, ADDR, DATA_IN,
        input  DATA_OUT, MFC, MAE
    );

    modport slave (
        input  MOV, R_W, TYPE, SIGN, ADDR, DATA_IN,
        output DATA_OUT, MFC, MAE
    );
endinterface

// File: rtl/sparc_ram_array.sv
// sparc_ram_array
//   DEPTH x 8 byte-addressed storage with a 4-byte big-endian window at
//   addr..addr+3.
//   clk   : write clock
//   addr  : base byte address of the window
//   we    : lane write enables, we[3] is the byte at addr (most significant)
//   wdata : write data, wdata[31:24] goes to addr
//   rdata : {m[addr], m[addr+1], m[addr+2], m[addr+3]}, combinational
module sparc_ram_array #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] lane_addr [4];

    // Lanes past the top of memory wrap; only unused lanes of byte and
    // halfword reads can ever land there.
    always_comb begin
        for (int i = 0; i < 4; i++) lane_addr[i] = addr + ADDR_W'(i);
    end

    assign rdata = {mem[lane_addr[0]], mem[lane_addr[1]],
                    mem[lane_addr[2]], mem[lane_addr[3]]};

    // Plain always so the storage can also be loaded by hierarchical
    // reference from outside the design.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[3-i]) mem[lane_addr[i]] <= wdata[31-8*i -: 8];
        end
    end
endmodule

// File: rtl/sparc_ram_responder.sv
// sparc_ram_responder
//   Memory-side responder: captures a byte/halfword/word request, waits
//   LATENCY cycles, commits the write or returns extended read data, then
//   holds MFC (or MAE for illegal requests) until MOV falls.
//   Clk : clock, rising edge
//   Clr : synchronous active-high reset (RAM contents preserved)
//   bus : request/response interface, slave side
module sparc_ram_responder
    import sparc_mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic                  Clk,
    input  logic                  Clr,
    sparc_ram_responder_if.slave  bus
);
    state_e            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              mfc_q, mfc_d, mae_q, mae_d;
    logic [31:0]       dout_q, dout_d;
    logic              capture;

    logic              r_w_q, sign_q;
    mem_type_e         type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;

    logic [3:0]        we, lane_mask;
    logic [31:0]       wdata, rdata, rd_ext;

    sparc_ram_array #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (Clk),
        .addr  (addr_q),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata)
    );

    // Size-dependent lane steering: narrow data sits in the top lanes
    // because the byte at the base address is the most significant.
    always_comb begin
        rd_ext    = rdata;
        wdata     = din_q;
        lane_mask = 4'b1111;
        case (type_q)
            MEM_BYTE: begin
                rd_ext    = {{24{sign_q & rdata[31]}}, rdata[31:24]};
                wdata     = {din_q[7:0], 24'h0};
                lane_mask = 4'b1000;
            end
            MEM_HALF: begin
                rd_ext    = {{16{sign_q & rdata[31]}}, rdata[31:16]};
                wdata     = {din_q[15:0], 16'h0};
                lane_mask = 4'b1100;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        mfc_d   = 1'b0;
        mae_d   = 1'b0;
        dout_d  = dout_q;
        capture = 1'b0;
        we      = 4'b0000;
        case (state)
            IDLE: begin
                if (bus.MOV) begin
                    capture = 1'b1;
                    if (req_legal(bus.TYPE, bus.ADDR[1:0])) begin
                        state_d = ACCESS;
                        cnt_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    state_d = DONE;
                    mfc_d   = 1'b1;
                    if (r_w_q) dout_d = rd_ext;
                    else       we     = lane_mask;
                end
            end
            DONE: begin
                if (bus.MOV) mfc_d   = 1'b1;
                else         state_d = IDLE;
            end
            ERR: begin
                // MAE rises one edge after capture and is held while MOV is.
                if (bus.MOV) mae_d   = 1'b1;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset abandons an in-flight access before it touches memory.
        if (Clr) we = 4'b0000;
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            mfc_q  <= 1'b0;
            mae_q  <= 1'b0;
            dout_q <= 32'h0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            mfc_q  <= mfc_d;
            mae_q  <= mae_d;
            dout_q <= dout_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (capture && !Clr) begin
            r_w_q  <= bus.R_W;
            type_q <= mem_type_e'(bus.TYPE);
            sign_q <= bus.SIGN;
            addr_q <= bus.ADDR;
            din_q  <= bus.DATA_IN;
        end
    end

    assign bus.DATA_OUT = dout_q;
    assign bus.MFC      = mfc_q;
    assign bus.MAE      = mae_q;
endmodule

// File: doc/sparc_ram_responder.md
# sparc_ram_responder

Memory-side responder for the SPARC MPU memory interface. Accepts a byte, halfword or word transfer request from the control unit, holds it for a fixed access latency, commits the write or returns the read data, then signals memory-function-complete (MFC). The handshake is four-phase: MOV is held until MFC rises, and MFC is held until MOV falls. Storage is a 512-byte, big-endian, byte-addressed RAM that MAR/MDR transfers target.

## Interface
- ADDR_W, 9, byte address width; DEPTH = 2**ADDR_W bytes.
- LATENCY, 2, access cycles from request capture to MFC; legal range 1..15.
- Clk  in  1  single clock, rising edge.
- Clr  in  1  reset, synchronous, active-high.
- MOV  in  1  request strobe; held high by the initiator until MFC or MAE is seen.
- R_W  in  1  1 = read (load), 0 = write (store).
- TYPE  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- SIGN  in  1  reads only: 1 = sign-extend byte/halfword, 0 = zero-extend.
- ADDR  in  ADDR_W  byte address.
- DATA_IN  in  32  store data, right-justified.
- DATA_OUT  out  32  load data, right-justified; holds its value until the next completed read.
- MFC  out  1  access complete.
- MAE  out  1  misaligned-address or illegal-type error.

## Operation
- States:
  - IDLE: no request in progress.
  - ACCESS: latency countdown.
  - DONE: MFC = 1.
  - ERR: MAE = 1.
- IDLE, MOV = 1 at a rising edge:
  - Capture R_W, TYPE, SIGN, ADDR and DATA_IN.
  - If the request is legal, go to ACCESS with cnt = LATENCY-1.
  - Otherwise go to ERR.
  - Input changes after capture are ignored until the request completes.
- Illegal requests:
  - TYPE = 11.
  - Halfword with ADDR[0] = 1.
  - Word with ADDR[1:0] != 0.
  - An illegal request never modifies memory or DATA_OUT.
- ACCESS:
  - cnt != 0: decrement cnt.
  - cnt = 0: perform the access and go to DONE.
- Access, big-endian:
  - The byte at address A is the most significant byte.
  - Word read: DATA_OUT = {m[A], m[A+1], m[A+2], m[A+3]}.
  - Halfword read: {ext16, m[A], m[A+1]}.
  - Byte read: {ext24, m[A]}.
  - ext = replicated MSB when SIGN = 1, zeros otherwise.
  - Writes store DATA_IN[31:0], [15:0] or [7:0] into the same byte positions.
  - Untouched bytes are preserved.
- DONE and ERR: hold the flag until an edge sees MOV = 0, then go to IDLE.
- Aligned accesses cannot cross the top of memory, so there is no address wrap.

## Timing
- Reset, at an edge with Clr = 1:
  - state = IDLE, MFC = 0, MAE = 0, DATA_OUT = 0, cnt = 0.
  - RAM contents are not cleared.
  - Clr takes priority over all activity. A request in ACCESS is abandoned and memory is left unchanged.
- Legal request captured at edge k:
  - Memory write or DATA_OUT update occurs at edge k+LATENCY.
  - MFC is 1 from edge k+LATENCY until the first edge with MOV = 0.
- Illegal request captured at edge k: MAE = 1 from edge k+1.
- MOV deasserted at edge j in DONE or ERR: flag = 0 from edge j.
  - The earliest next capture is edge j+1, provided MOV = 1 there.
  - MOV must therefore be low for at least one edge between requests.
- MOV dropped early (during ACCESS): the access still completes. MFC pulses for one cycle, then the block returns to IDLE.
- MFC and MAE are never high together. Both are registered outputs.

## Structure
- Package sparc_mem_pkg:
  - TYPE encodings (MEM_BYTE, MEM_HALF, MEM_WORD).
  - State enum (IDLE, ACCESS, DONE, ERR).
  - Alignment-check function.
- Sub-module sparc_ram_array:
  - DEPTH x 8 storage with four byte-lane write enables and a 4-byte big-endian read port at A..A+3.
  - Accessible by hierarchical path for bench preloading.
- Top level contains the FSM, latency counter, request capture registers and extension logic.

## Test plan
- Clr, then a word write of 0xDEADBEEF to 0x010, then a word read of 0x010 with LATENCY = 2 -> MFC high exactly 2 edges after each capture; DATA_OUT = 0xDEADBEEF.
- After that write, byte reads of 0x010 with SIGN = 1 and SIGN = 0 -> 0xFFFFFFDE and 0x000000DE; halfword read of 0x012 with SIGN = 1 -> 0xFFFFBEEF.
- Byte write of 0x55 to 0x011, then word read of 0x010 -> 0xDE55BEEF, confirming other lanes are preserved.
- Halfword request at 0x013 and word request at 0x012 -> MAE at edge k+1, MFC stays 0, memory and DATA_OUT unchanged.
- Clr asserted mid-ACCESS of a word write to 0x020 -> outputs zero next edge; a subsequent read of 0x020 returns the old contents.
- Preload via the array path, then the initiator holds MOV after MFC for 3 extra cycles -> MFC stays high for those cycles, drops at the edge seeing MOV = 0, and a second capture occurs no earlier than the following edge.
